// File: rtl/ahci_dma_rd_pkg.sv
// Shared definitions for the AHCI DMA read-burst issuer: FSM states and
// AXI/page constants.
package ahci_dma_rd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      CREDIT,
      ADDR,
      DRAIN
   } state_t;

   localparam int AXI_SIZE    = 3;
   localparam int PAGE_QWORDS = 512;

endpackage

// File: rtl/ahci_dma_rd_burst_len.sv
// Combinational burst-length selector: min of MAX_BURST, remaining QWORDs and,
// with AHCI_DMA_RD_BOUNDARY_4K_EN, the QWORDs left before the next 4 KB page.
module ahci_dma_rd_burst_len
   import ahci_dma_rd_pkg::*;
#(
   parameter int RW        = 22,
   parameter int MAX_BURST = 16
) (
   input  logic [RW-1:0] remain,
   input  logic [8:0]    page_idx,
   output logic [4:0]    len
);

   logic [4:0] cap;

   always_comb begin
      cap = 5'(MAX_BURST);
      if (remain < RW'(MAX_BURST)) cap = 5'(remain);
   end

`ifdef AHCI_DMA_RD_BOUNDARY_4K_EN
   logic [9:0] to_page;

   assign to_page = 10'(PAGE_QWORDS) - {1'b0, page_idx};
   assign len     = ({5'b0, cap} > to_page) ? 5'(to_page) : cap;
`else
   logic page_unused;

   assign page_unused = ^page_idx;
   assign len         = cap;
`endif

endmodule

// File: rtl/ahci_dma_rd_burst.sv
// AHCI PRD-region read-burst issuer with downstream credit flow control.
// Optional macro AHCI_DMA_RD_BOUNDARY_4K_EN keeps bursts inside 4 KB pages.
module ahci_dma_rd_burst
   import ahci_dma_rd_pkg::*;
#(
   parameter int WCNT_BITS = 21,
   parameter int MAX_BURST = 16,
   parameter int CREDITS   = 16
) (
   input  logic                 hclk,
   input  logic                 hrst_n,
   input  logic                 prd_start,
   input  logic [31:0]          prd_addr,
   input  logic [WCNT_BITS-1:0] prd_wcnt,
   input  logic                 abort,
   output logic [31:0]          araddr,
   output logic [3:0]           arlen,
   output logic                 arvalid,
   input  logic                 arready,
   input  logic                 r_beat,
   input  logic                 qw_free,
   output logic                 rd_start,
   output logic [WCNT_BITS-1:0] rd_wcnt,
   output logic [1:0]           rd_woffs,
   output logic                 busy,
   output logic                 done
);

   localparam int RW = WCNT_BITS + 1;
   localparam int CW = $clog2(CREDITS + 1) + 1;

   state_t               state, state_d;
   logic [31:0]          addr_q, addr_d;
   logic [RW-1:0]        remain_q, remain_d, qw_sum;
   logic [4:0]           len_q, len_d, len_c;
   logic [CW-1:0]        credit_q, credit_d, outst_q, outst_d, hs_len;
   logic [CW:0]          credit_sum;
   logic [31:0]          araddr_d;
   logic [3:0]           arlen_d;
   logic                 arvalid_d, rd_start_d, busy_d, done_d, hs;
   logic [WCNT_BITS-1:0] rd_wcnt_d;
   logic [1:0]           rd_woffs_d;
   logic                 addr_unused;

   assign addr_unused = prd_addr[0];
   assign hs          = arvalid && arready;
   assign hs_len      = hs ? CW'(len_q) : '0;
   assign qw_sum      = RW'(prd_addr[2:1]) + RW'(prd_wcnt);

   ahci_dma_rd_burst_len #(
      .RW        (RW),
      .MAX_BURST (MAX_BURST)
   ) u_len (
      .remain   (remain_q),
      .page_idx (addr_q[11:3]),
      .len      (len_c)
   );

   // Credit and outstanding take the net of this cycle's events; credit saturates after the net.
   always_comb begin
      credit_sum = {1'b0, credit_q} + (CW+1)'(qw_free) - {1'b0, hs_len};
      credit_d   = (credit_sum > (CW+1)'(CREDITS)) ? CW'(CREDITS) : credit_sum[CW-1:0];
      outst_d    = outst_q + hs_len - CW'(r_beat);
      state_d    = state;
      addr_d     = addr_q;
      remain_d   = remain_q;
      len_d      = len_q;
      arvalid_d  = arvalid;
      araddr_d   = araddr;
      arlen_d    = arlen;
      rd_start_d = 1'b0;
      rd_wcnt_d  = rd_wcnt;
      rd_woffs_d = rd_woffs;
      busy_d     = busy;
      done_d     = 1'b0;
      case (state)
         IDLE: begin
            if (prd_start) begin
               state_d    = CALC;
               addr_d     = {prd_addr[31:3], 3'b000};
               remain_d   = (qw_sum >> 2) + RW'(1);
               rd_start_d = 1'b1;
               rd_wcnt_d  = prd_wcnt;
               rd_woffs_d = prd_addr[2:1];
               busy_d     = 1'b1;
            end
         end
         CALC: begin
            if (abort) begin
               state_d = DRAIN;
            end else begin
               len_d   = len_c;
               state_d = CREDIT;
            end
         end
         CREDIT: begin
            if (abort) begin
               state_d = DRAIN;
            end else if (credit_q >= CW'(len_q)) begin
               state_d   = ADDR;
               arvalid_d = 1'b1;
               araddr_d  = addr_q;
               arlen_d   = 4'(len_q - 5'd1);
            end
         end
         ADDR: begin
            if (hs) begin
               arvalid_d = 1'b0;
               addr_d    = addr_q + (32'(len_q) << AXI_SIZE);
               remain_d  = remain_q - RW'(len_q);
               state_d   = (remain_d != '0 && !abort) ? CALC : DRAIN;
            end
         end
         DRAIN: begin
            if (outst_q == '0) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hrst_n) begin
      if (!hrst_n) begin
         state    <= IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         len_q    <= '0;
         credit_q <= CW'(CREDITS);
         outst_q  <= '0;
         arvalid  <= 1'b0;
         araddr   <= '0;
         arlen    <= '0;
         rd_start <= 1'b0;
         rd_wcnt  <= '0;
         rd_woffs <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         len_q    <= len_d;
         credit_q <= credit_d;
         outst_q  <= outst_d;
         arvalid  <= arvalid_d;
         araddr   <= araddr_d;
         arlen    <= arlen_d;
         rd_start <= rd_start_d;
         rd_wcnt  <= rd_wcnt_d;
         rd_woffs <= rd_woffs_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

   a_no_underflow: assert property (@(posedge hclk) disable iff (!hrst_n)
      !(r_beat && !hs && outst_q == '0));

endmodule

// File: tb/tb_ahci_dma_rd_burst.sv
// Directed self-checking bench for ahci_dma_rd_burst; burst tables follow
// AHCI_DMA_RD_BOUNDARY_4K_EN when it is defined.
module tb_ahci_dma_rd_burst;

   localparam int WCNT_BITS = 21;

   logic                 hclk = 1'b0;
   logic                 hrst_n = 1'b0;
   logic                 prd_start = 1'b0;
   logic [31:0]          prd_addr = '0;
   logic [WCNT_BITS-1:0] prd_wcnt = '0;
   logic                 abort = 1'b0;
   logic [31:0]          araddr;
   logic [3:0]           arlen;
   logic                 arvalid;
   logic                 arready = 1'b0;
   logic                 r_beat = 1'b0;
   logic                 qw_free = 1'b0;
   logic                 rd_start;
   logic [WCNT_BITS-1:0] rd_wcnt;
   logic [1:0]           rd_woffs;
   logic                 busy;
   logic                 done;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int base;

`ifdef AHCI_DMA_RD_BOUNDARY_4K_EN
   localparam int S2_N = 5;
   int s2_addr [S2_N] = '{32'hFC0, 32'h1000, 32'h1080, 32'h1100, 32'h1180};
   int s2_len  [S2_N] = '{7, 15, 15, 15, 7};
`else
   localparam int S2_N = 4;
   int s2_addr [S2_N] = '{32'hFC0, 32'h1040, 32'h10C0, 32'h1140};
   int s2_len  [S2_N] = '{15, 15, 15, 15};
`endif

   ahci_dma_rd_burst #(
      .WCNT_BITS (WCNT_BITS),
      .MAX_BURST (16),
      .CREDITS   (16)
   ) dut (
      .hclk      (hclk),
      .hrst_n    (hrst_n),
      .prd_start (prd_start),
      .prd_addr  (prd_addr),
      .prd_wcnt  (prd_wcnt),
      .abort     (abort),
      .araddr    (araddr),
      .arlen     (arlen),
      .arvalid   (arvalid),
      .arready   (arready),
      .r_beat    (r_beat),
      .qw_free   (qw_free),
      .rd_start  (rd_start),
      .rd_wcnt   (rd_wcnt),
      .rd_woffs  (rd_woffs),
      .busy      (busy),
      .done      (done)
   );

   always #5 hclk = ~hclk;

   always @(posedge hclk) if (done) done_cnt <= done_cnt + 1;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock with the given handshake/beat/free levels, then back to idle levels.
   task automatic stepCycle(input logic rdy, input logic beat, input logic free);
      arready = rdy;
      r_beat  = beat;
      qw_free = free;
      @(posedge hclk);
      #1;
      arready = 1'b0;
      r_beat  = 1'b0;
      qw_free = 1'b0;
   endtask

   task automatic resetDut();
      hrst_n = 1'b0;
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      hrst_n = 1'b1;
      @(posedge hclk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [WCNT_BITS-1:0] wcnt);
      prd_addr  = addr;
      prd_wcnt  = wcnt;
      prd_start = 1'b1;
      @(posedge hclk);
      #1;
      prd_start = 1'b0;
   endtask

   task automatic waitArvalid(input string tag, input int budget);
      int n = 0;
      while (!arvalid && n < budget) begin
         stepCycle(1'b0, 1'b0, 1'b0);
         n++;
      end
      checkOutput(tag, 32'(arvalid), 32'd1);
   endtask

   task automatic waitDone(input string tag, input int budget);
      int n = 0;
      while (!done && n < budget) begin
         stepCycle(1'b0, 1'b0, 1'b0);
         n++;
      end
      checkOutput(tag, 32'(done), 32'd1);
   endtask

   task automatic doBurst(input string tag, input logic [31:0] a, input logic [3:0] l, input logic free);
      waitArvalid({tag, "_arvalid"}, 40);
      checkOutput({tag, "_araddr"}, araddr, a);
      checkOutput({tag, "_arlen"}, 32'(arlen), 32'(l));
      stepCycle(1'b1, 1'b0, 1'b0);
      for (int b = 0; b <= int'(l); b++) stepCycle(1'b0, 1'b1, free);
   endtask

   initial begin
      $display("[TB] start");
      resetDut();
      checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_rd_start", 32'(rd_start), 32'd0);
      checkOutput("rst_araddr", araddr, 32'd0);
      checkOutput("rst_arlen", 32'(arlen), 32'd0);
      checkOutput("rst_rd_wcnt", 32'(rd_wcnt), 32'd0);

      // Scenario 1: unaligned start, three QWORDs in one burst
      applyStimulus(32'h1000_0002, 21'd9);
      checkOutput("s1_rd_start", 32'(rd_start), 32'd1);
      checkOutput("s1_rd_woffs", 32'(rd_woffs), 32'd1);
      checkOutput("s1_rd_wcnt", 32'(rd_wcnt), 32'd9);
      checkOutput("s1_busy", 32'(busy), 32'd1);
      stepCycle(1'b0, 1'b0, 1'b0);
      checkOutput("s1_rd_start_pulse", 32'(rd_start), 32'd0);
      base = done_cnt;
      waitArvalid("s1_arvalid", 20);
      checkOutput("s1_araddr", araddr, 32'h1000_0000);
      checkOutput("s1_arlen", 32'(arlen), 32'd2);
      stepCycle(1'b1, 1'b0, 1'b0);
      checkOutput("s1_arvalid_drop", 32'(arvalid), 32'd0);
      stepCycle(1'b0, 1'b1, 1'b1);
      stepCycle(1'b0, 1'b1, 1'b1);
      stepCycle(1'b0, 1'b0, 1'b0);
      checkOutput("s1_no_early_done", 32'(done_cnt - base), 32'd0);
      stepCycle(1'b0, 1'b1, 1'b1);
      checkOutput("s1_done_after_last_beat", 32'(done), 32'd0);
      waitDone("s1_done", 5);
      stepCycle(1'b0, 1'b0, 1'b0);
      checkOutput("s1_done_pulse", 32'(done), 32'd0);
      checkOutput("s1_busy_end", 32'(busy), 32'd0);
      checkOutput("s1_done_count", 32'(done_cnt - base), 32'd1);

      // Scenario 2: 64 QWORDs from 0xFC0 with credit returned per beat; a second start while busy is ignored
      resetDut();
      applyStimulus(32'hFC0, 21'd255);
      checkOutput("s2_rd_start", 32'(rd_start), 32'd1);
      prd_addr  = 32'h5000;
      prd_wcnt  = 21'd3;
      prd_start = 1'b1;
      stepCycle(1'b0, 1'b0, 1'b0);
      prd_start = 1'b0;
      checkOutput("s2_busy_start_ignored", 32'(rd_start), 32'd0);
      checkOutput("s2_rd_wcnt_kept", 32'(rd_wcnt), 32'd255);
      for (int i = 0; i < S2_N; i++)
         doBurst($sformatf("s2_b%0d", i), s2_addr[i], 4'(s2_len[i]), 1'b1);
      stepCycle(1'b0, 1'b0, 1'b0);
      checkOutput("s2_no_extra_burst", 32'(arvalid), 32'd0);
      waitDone("s2_done", 10);
      stepCycle(1'b0, 1'b0, 1'b0);
      checkOutput("s2_busy_end", 32'(busy), 32'd0);

      // Scenario 3: no credit returned, second burst must wait for exactly the missing credit
      resetDut();
      applyStimulus(32'hFC0, 21'd255);
      waitArvalid("s3_b0_arvalid", 20);
      checkOutput("s3_b0_araddr", araddr, 32'hFC0);
      checkOutput("s3_b0_arlen", 32'(arlen), 32'(s2_len[0]));
      stepCycle(1'b1, 1'b0, 1'b0);
      for (int b = 0; b <= s2_len[0]; b++) stepCycle(1'b0, 1'b1, 1'b0);
      for (int f = 0; f < s2_len[0]; f++) stepCycle(1'b0, 1'b0, 1'b1);
      repeat (5) stepCycle(1'b0, 1'b0, 1'b0);
      checkOutput("s3_credit_wait", 32'(arvalid), 32'd0);
      stepCycle(1'b0, 1'b0, 1'b1);
      waitArvalid("s3_credit_release", 6);
      for (int i = 1; i < S2_N; i++)
         doBurst($sformatf("s3_b%0d", i), s2_addr[i], 4'(s2_len[i]), 1'b1);
      waitDone("s3_done", 10);

      // Scenario 4: abort while a request is stalled
      resetDut();
      base = done_cnt;
      applyStimulus(32'h0, 21'd255);
      waitArvalid("s4_arvalid", 20);
      abort = 1'b1;
      repeat (3) stepCycle(1'b0, 1'b0, 1'b0);
      checkOutput("s4_hold_arvalid", 32'(arvalid), 32'd1);
      checkOutput("s4_hold_araddr", araddr, 32'h0);
      checkOutput("s4_hold_arlen", 32'(arlen), 32'd15);
      stepCycle(1'b1, 1'b0, 1'b0);
      begin
         logic av_seen = 1'b0;
         for (int b = 0; b < 16; b++) begin
            stepCycle(1'b0, 1'b1, 1'b1);
            av_seen |= arvalid;
         end
         waitDone("s4_done", 6);
         av_seen |= arvalid;
         checkOutput("s4_no_new_arvalid", 32'(av_seen), 32'd0);
      end
      stepCycle(1'b0, 1'b0, 1'b0);
      abort = 1'b0;
      checkOutput("s4_done_count", 32'(done_cnt - base), 32'd1);
      checkOutput("s4_busy_end", 32'(busy), 32'd0);

      // Scenario 5: reset in DRAIN, then a clean region needing full credit
      resetDut();
      applyStimulus(32'h0, 21'd7);
      waitArvalid("s5_arvalid", 20);
      checkOutput("s5_arlen", 32'(arlen), 32'd1);
      stepCycle(1'b1, 1'b0, 1'b0);
      stepCycle(1'b0, 1'b1, 1'b0);
      base = done_cnt;
      #2 hrst_n = 1'b0;
      #1;
      checkOutput("s5_rst_arvalid", 32'(arvalid), 32'd0);
      checkOutput("s5_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge hclk);
      hrst_n = 1'b1;
      @(posedge hclk);
      #1;
      repeat (3) stepCycle(1'b0, 1'b0, 1'b0);
      checkOutput("s5_no_done", 32'(done_cnt - base), 32'd0);
      applyStimulus(32'h2000, 21'd63);
      checkOutput("s5_rd_start", 32'(rd_start), 32'd1);
      doBurst("s5_b0", 32'h2000, 4'd15, 1'b0);
      waitDone("s5_done", 6);
      stepCycle(1'b0, 1'b0, 1'b0);
      checkOutput("s5_done_count", 32'(done_cnt - base), 32'd1);

      // Scenario 6: handshake, r_beat and qw_free in one cycle
      resetDut();
      applyStimulus(32'h0, 21'd79);
      waitArvalid("s6_b0_arvalid", 20);
      checkOutput("s6_b0_arlen", 32'(arlen), 32'd15);
      stepCycle(1'b1, 1'b0, 1'b0);
      repeat (4) stepCycle(1'b0, 1'b1, 1'b1);
      waitArvalid("s6_b1_arvalid", 10);
      checkOutput("s6_b1_araddr", araddr, 32'h80);
      checkOutput("s6_b1_arlen", 32'(arlen), 32'd3);
      stepCycle(1'b1, 1'b1, 1'b1);
      base = done_cnt;
      repeat (14) stepCycle(1'b0, 1'b1, 1'b0);
      repeat (3) stepCycle(1'b0, 1'b0, 1'b0);
      checkOutput("s6_outstanding_15", 32'(done_cnt - base) + 32'(done), 32'd0);
      stepCycle(1'b0, 1'b1, 1'b0);
      waitDone("s6_done", 5);
      stepCycle(1'b0, 1'b0, 1'b0);
      checkOutput("s6_done_count", 32'(done_cnt - base), 32'd1);
      applyStimulus(32'h3000, 21'd63);
      repeat (14) stepCycle(1'b0, 1'b0, 1'b1);
      repeat (5) stepCycle(1'b0, 1'b0, 1'b0);
      checkOutput("s6_credit_1_hold", 32'(arvalid), 32'd0);
      stepCycle(1'b0, 1'b0, 1'b1);
      doBurst("s6_b2", 32'h3000, 4'd15, 1'b1);
      waitDone("s6_done2", 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ahci_dma_rd_burst.md
AHCI_DMA_RD_BURST -- requirements
Module: ahci_dma_rd_burst

Interface
REQ-001 Parameter WCNT_BITS, default 21, width of the 0-based 16-bit-word count.
REQ-002 Parameter MAX_BURST, default 16, maximum QWORD beats per AXI read burst (power of 2, at most 16).
REQ-003 Parameter CREDITS, default 16, QWORD slots available downstream at reset (at least MAX_BURST).
REQ-004 Ports, one per line:
- hclk  in  1  sole clock.
- hrst_n  in  1  reset, asynchronous, active-low.
- prd_start  in  1  one-cycle pulse starting one PRD region.
- prd_addr  in  32  region byte address; bit 0 is ignored.
- prd_wcnt  in  WCNT_BITS  16-bit word count minus 1.
- abort  in  1  stop issuing new bursts.
- araddr  out  32  QWORD-aligned burst address.
- arlen  out  4  beats minus 1.
- arvalid  out  1  address request valid.
- arready  in  1  address request accepted.
- r_beat  in  1  one 64-bit read beat accepted downstream.
- qw_free  in  1  one QWORD slot released downstream.
- rd_start  out  1  pulse to the realigning FIFO.
- rd_wcnt  out  WCNT_BITS  word count forwarded to the FIFO.
- rd_woffs  out  2  word offset forwarded to the FIFO.
- busy  out  1  region in progress.
- done  out  1  one-cycle pulse when the region is complete.

Function
REQ-005 On prd_start while idle, the block SHALL register prd_addr and prd_wcnt; it SHALL assert rd_start on the next cycle with rd_woffs=prd_addr[2:1] and rd_wcnt=prd_wcnt; busy SHALL go high on that same cycle.
REQ-006 Total QWORDs SHALL be ((prd_addr[2:1]+prd_wcnt)>>2)+1, computed at WCNT_BITS+1 width with no overflow.
REQ-007 Each burst length SHALL be min(MAX_BURST, remaining QWORDs, QWORDs to the next 4 KB boundary), where QWORDs to boundary = 512-addr[11:3].
REQ-008 The FSM SHALL have states IDLE, CALC, CREDIT, ADDR, DRAIN, with these transitions:
- IDLE to CALC on prd_start.
- CALC to CREDIT.
- CREDIT to ADDR when credit >= burst length.
- ADDR to CALC on arvalid&&arready if QWORDs remain and abort is low; otherwise ADDR to DRAIN.
- DRAIN to IDLE when the outstanding count is 0; done pulses on this transition.
REQ-009 arvalid, araddr and arlen SHALL be driven from registers and SHALL stay stable while arvalid&&!arready.
REQ-010 On each AR handshake, the block SHALL decrement credit by arlen+1, increment outstanding by arlen+1, advance the address by (arlen+1)*8, and decrement the remaining count.
REQ-011 Credit SHALL increment by 1 on qw_free; outstanding SHALL decrement by 1 on r_beat. When these coincide with a handshake, the block SHALL apply the net sum in the same cycle.
REQ-012 Credit SHALL saturate at CREDITS; outstanding underflow is a checked error (assertion).
REQ-013 When abort is high, the block SHALL issue no new burst; an ADDR request already pending SHALL complete its handshake; the block then SHALL go to DRAIN.
REQ-014 prd_start while busy SHALL be ignored.
REQ-015 done SHALL occur at least 1 cycle after the last r_beat of the region.

Reset
REQ-016 hrst_n low SHALL take effect asynchronously and SHALL put the block in state IDLE with credit=CREDITS, outstanding=0, and all outputs 0.
REQ-017 Reset mid-burst SHALL discard all in-flight accounting, and no done SHALL be produced.

Configuration
REQ-018 With macro AHCI_DMA_RD_BOUNDARY_4K_EN defined, the 4 KB term of REQ-007 SHALL apply.
REQ-019 Without AHCI_DMA_RD_BOUNDARY_4K_EN, bursts SHALL be limited only by MAX_BURST and the remaining count.

Structure
REQ-020 Package ahci_dma_rd_pkg SHALL hold the FSM state enum, the AXI size constant (3), and the 4 KB page QWORD count (512).
REQ-021 Burst-length arithmetic SHALL be a sub-module, ahci_dma_rd_burst_len (combinational min).

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Scenario 1: addr=0x10000002, wcnt=9 -> rd_woffs=1, rd_wcnt=9, one burst araddr=0x10000000, arlen=2; done after the 3rd r_beat.
- Scenario 2: addr=0xFC0, wcnt=255, 4K_EN defined, qw_free returned per beat -> bursts at 0xFC0/7, 0x1000/15, 0x1080/15, 0x1100/15, 0x1180/7.
- Scenario 3: same as scenario 2 with no qw_free -> the 2nd burst SHALL wait in CREDIT (credit=8), then SHALL proceed after 8 qw_free pulses.
- Scenario 4: abort asserted while arvalid is high and arready is held low for 3 cycles -> the pending request completes, no further arvalid, done once the outstanding count reaches 0.
- Scenario 5: hrst_n pulled low mid-DRAIN -> arvalid=0, busy=0 immediately; a new prd_start afterwards runs normally with credit=16.
- Scenario 6: r_beat, qw_free and an AR handshake (arlen=3) in the same cycle -> credit changes by -3 and outstanding by +3.
